// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control sequencer: state encoding,
// opcodes, datapath select encodings and the per-state control decode.
package mc_ctrl_pkg;

    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDI_EX = 4'd10,
        ADDI_WB = 4'd11,
        HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REGB     = 2'b00,
        SRCB_FOUR     = 2'b01,
        SRCB_SEXT     = 2'b10,
        SRCB_SEXT_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_e;

    // Controls that depend on state alone; ready-gated strobes are added in the top.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_source_e pc_source;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            DECODE:  c.alu_src_b = SRCB_SEXT_SH2;
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_SEXT;
            end
            ADDI_WB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // States whose single cycle retires an instruction unconditionally.
    function automatic logic retires(state_e s);
        return (s == MEMWB) || (s == RWB) || (s == BRANCH) ||
               (s == JUMP)  || (s == ADDI_WB);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the MIPS datapath/memory (slave).
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, bus_error
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, bus_error
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags the
// cycle in which the WAIT_LIMIT-th wait passes without mem_ready.
module mem_wait_timer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_LIMIT - 1);

    logic [WAIT_CNT_W-1:0] count_q, count_d;
    logic                  stalled;

    assign stalled = waiting && !mem_ready;
    assign timeout = stalled && (count_q == LAST_WAIT);

    // Leaving or re-entering a wait state always passes through a non-stalled cycle, which clears the count.
    always_comb begin
        count_d = stalled ? count_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC-MEM/WRITEBACK with a
// mem_ready handshake and bus-error timeout. Optional macro: PERF_COUNTERS_EN.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_fsm_if.master    bus
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 retired_count
`endif
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   retire_q, retire_d;
    logic   bus_error_q, bus_error_d;
    logic   illegal;
    logic   waiting;
    logic   timeout;
    logic   fetch_done;
    logic   instr_done;

    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .waiting   (waiting),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) state_d = DECODE;
                else if (timeout)  state_d = HALT;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (bus.mem_ready) state_d = MEMWB;
                else if (timeout)  state_d = HALT;
            end
            MEMWR: begin
                if (bus.mem_ready) state_d = FETCH;
                else if (timeout)  state_d = HALT;
            end
            EXEC:    state_d = RWB;
            ADDI_EX: state_d = ADDI_WB;
            MEMWB, RWB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
        ctrl_d      = state_ctrl(state_d);
        retire_d    = retires(state_d);
        bus_error_d = bus_error_q || timeout;
    end

    // Moore controls are decoded from the next state so they leave a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            ctrl_q      <= state_ctrl(FETCH);
            retire_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            retire_q    <= retire_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Write strobes are masked while reset is held so an interrupted state commits nothing.
    assign fetch_done = (state_q == FETCH) && bus.mem_ready;
    assign instr_done = !reset && (retire_q || ((state_q == MEMWR) && bus.mem_ready));

    assign bus.pc_write      = !reset && (ctrl_q.pc_write || fetch_done);
    assign bus.ir_write      = !reset && fetch_done;
    assign bus.pc_write_cond = !reset && ctrl_q.pc_write_cond;
    assign bus.mem_write     = !reset && ctrl_q.mem_write;
    assign bus.reg_write     = !reset && ctrl_q.reg_write;
    assign bus.iord          = ctrl_q.iord;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.state         = state_q;
    assign bus.instr_done    = instr_done;
    assign bus.illegal_op    = !reset && illegal;
    assign bus.bus_error     = bus_error_q;

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] retired_count_q, retired_count_d;

    always_comb begin
        cycle_count_d   = cycle_count_q + ((state_q != HALT) ? 32'd1 : 32'd0);
        retired_count_d = retired_count_q + (instr_done ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomised bench for multicycle_control_fsm: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_multicycle_control_fsm;

    localparam int WL = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_RWB = 7,
                   S_BRANCH = 8, S_JUMP = 9, S_ADDI_EX = 10, S_ADDI_WB = 11,
                   S_HALT = 12;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_error;
    } obs_t;

    typedef struct {
        obs_t       exp;
        logic       rdy;
        logic [5:0] op;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc_m = 0;
    int   ret_m = 0;
    cyc_t trace[$];

    multicycle_control_fsm_if bus ();

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count, retired_count;
`endif

    multicycle_control_fsm #(
        .WAIT_LIMIT (WL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic bit legal(logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
    endfunction

    // Expected outputs of one cycle, straight from the per-state control table.
    function automatic obs_t exp_state(int st, logic rdy);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            S_FETCH:   begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            S_DECODE:  o.alu_src_b = 2'b11;
            S_MEMADR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_MEMRD:   begin o.mem_read = 1; o.iord = 1; end
            S_MEMWB:   begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            S_MEMWR:   begin o.mem_write = 1; o.iord = 1; o.instr_done = rdy; end
            S_EXEC:    begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            S_RWB:     begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            S_BRANCH:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                             o.pc_source = 2'b01; o.instr_done = 1; end
            S_JUMP:    begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
            S_ADDI_EX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            S_ADDI_WB: begin o.reg_write = 1; o.instr_done = 1; end
            S_HALT:    o.bus_error = 1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st            = bus.state;
        o.pc_write      = bus.pc_write;
        o.pc_write_cond = bus.pc_write_cond;
        o.iord          = bus.iord;
        o.mem_read      = bus.mem_read;
        o.mem_write     = bus.mem_write;
        o.ir_write      = bus.ir_write;
        o.mem_to_reg    = bus.mem_to_reg;
        o.reg_dst       = bus.reg_dst;
        o.reg_write     = bus.reg_write;
        o.alu_src_a     = bus.alu_src_a;
        o.alu_src_b     = bus.alu_src_b;
        o.alu_op        = bus.alu_op;
        o.pc_source     = bus.pc_source;
        o.instr_done    = bus.instr_done;
        o.illegal_op    = bus.illegal_op;
        o.bus_error     = bus.bus_error;
        return o;
    endfunction

    task automatic push(int st, logic rdy, logic [5:0] op, bit ill);
        cyc_t c;
        c.exp = exp_state(st, rdy);
        c.exp.illegal_op = ill;
        c.rdy = rdy;
        c.op  = op;
        trace.push_back(c);
    endtask

    // A memory access that stays not-ready for d cycles; d >= WL ends in a bus error.
    task automatic mem_phase(int st, int d, logic [5:0] op, output bit hung);
        hung = 0;
        for (int i = 0; i < d && i < WL; i++)
            push(st, 1'b0, (st == S_FETCH) ? 6'($urandom) : op, 0);
        if (d >= WL) hung = 1;
        else push(st, 1'b1, (st == S_FETCH) ? 6'($urandom) : op, 0);
    endtask

    task automatic add_instr(logic [5:0] op, int d_fetch, int d_mem, output bit hung);
        mem_phase(S_FETCH, d_fetch, op, hung);
        if (hung) return;
        push(S_DECODE, 1'($urandom), op, !legal(op));
        case (op)
            T_R:    begin push(S_EXEC, 1'($urandom), op, 0); push(S_RWB, 1'($urandom), op, 0); end
            T_LW:   begin
                        push(S_MEMADR, 1'($urandom), op, 0);
                        mem_phase(S_MEMRD, d_mem, op, hung);
                        if (!hung) push(S_MEMWB, 1'($urandom), op, 0);
                    end
            T_SW:   begin
                        push(S_MEMADR, 1'($urandom), op, 0);
                        mem_phase(S_MEMWR, d_mem, op, hung);
                    end
            T_BEQ:  push(S_BRANCH, 1'($urandom), op, 0);
            T_J:    push(S_JUMP, 1'($urandom), op, 0);
            T_ADDI: begin push(S_ADDI_EX, 1'($urandom), op, 0); push(S_ADDI_WB, 1'($urandom), op, 0); end
            default: ;
        endcase
    endtask

    task automatic add_halt(int n);
        for (int i = 0; i < n; i++) push(S_HALT, 1'($urandom), 6'($urandom), 0);
    endtask

    task automatic run_trace(string name);
        int n;
        n = 0;
        while (trace.size() > 0) begin
            cyc_t c;
            obs_t got;
            c = trace.pop_front();
            @(negedge clk);
            bus.mem_ready = c.rdy;
            bus.opcode    = c.op;
            #1;
            got = sample();
            checks++;
            if (got !== c.exp) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
                         name, n, got, got.st, c.exp, c.exp.st);
            end
`ifdef PERF_COUNTERS_EN
            checks++;
            if (cycle_count !== 32'(cyc_m) || retired_count !== 32'(ret_m)) begin
                failures++;
                $display("FAIL %s perf cycle %0d: got cycles=%0d retired=%0d expected cycles=%0d retired=%0d",
                         name, n, cycle_count, retired_count, cyc_m, ret_m);
            end
`endif
            @(posedge clk);
            if (c.exp.st != 4'(S_HALT)) cyc_m++;
            if (c.exp.instr_done) ret_m++;
            n++;
        end
    endtask

    // One reset cycle with mem_ready high: no write strobe may escape while reset is held.
    task automatic do_reset(string name);
        logic [4:0] wr;
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'($urandom);
        #1;
        wr = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write, bus.mem_write};
        checks++;
        if (wr !== 5'b0) begin
            failures++;
            $display("FAIL %s reset-cycle writes: got %b expected 00000", name, wr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc_m = 0;
        ret_m = 0;
    endtask

    task automatic test_reset();
        bit h;
        do_reset("reset");
        add_instr(T_R, 2, 0, h);
        run_trace("reset_then_rtype");
    endtask

    task automatic test_lw();
        bit h;
        do_reset("lw");
        add_instr(T_LW, 0, 0, h);
        run_trace("lw_ready_high");
    endtask

    task automatic test_sw_wait();
        bit h;
        do_reset("sw");
        add_instr(T_SW, 0, 3, h);
        add_instr(T_SW, WL - 1, WL - 1, h);
        add_instr(T_ADDI, 0, 0, h);
        run_trace("sw_wait");
    endtask

    task automatic test_beq_j();
        bit h;
        do_reset("beq_j");
        add_instr(T_BEQ, 0, 0, h);
        add_instr(T_J, 0, 0, h);
        run_trace("beq_j");
    endtask

    task automatic test_illegal();
        bit h;
        do_reset("illegal");
        add_instr(6'b111111, 0, 0, h);
        add_instr(T_LW, 1, 1, h);
        run_trace("illegal_op");
    endtask

    task automatic test_timeout();
        bit h;
        do_reset("timeout");
        add_instr(T_LW, WL, 0, h);
        add_halt(3);
        run_trace("fetch_timeout");
        do_reset("timeout_exit");
        add_instr(T_J, 0, 0, h);
        add_instr(T_LW, 0, WL, h);
        add_halt(2);
        run_trace("memrd_timeout");
        do_reset("timeout_exit2");
        add_instr(T_SW, 0, WL, h);
        add_halt(2);
        run_trace("memwr_timeout");
        do_reset("timeout_exit3");
        add_instr(T_BEQ, 0, 0, h);
        run_trace("after_timeout");
    endtask

    task automatic test_reset_mid();
        bit h;
        do_reset("mid");
        push(S_FETCH, 1'b1, T_LW, 0);
        push(S_DECODE, 1'b0, T_LW, 0);
        push(S_MEMADR, 1'b0, T_LW, 0);
        push(S_MEMRD, 1'b0, T_LW, 0);
        push(S_MEMRD, 1'b0, T_LW, 0);
        run_trace("mid_memrd_wait");
        do_reset("reset_in_memrd");
        add_instr(T_ADDI, 0, 0, h);
        push(S_FETCH, 1'b1, T_LW, 0);
        push(S_DECODE, 1'b0, T_LW, 0);
        push(S_MEMADR, 1'b0, T_LW, 0);
        push(S_MEMRD, 1'b1, T_LW, 0);
        run_trace("to_memwb");
        do_reset("reset_in_memwb");
        add_instr(T_R, 0, 0, h);
        run_trace("after_reset_memwb");
    endtask

    task automatic test_back_to_back();
        bit h;
        logic [5:0] ops[6] = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
        do_reset("random");
        for (int i = 0; i < 60; i++) begin
            logic [5:0] op;
            int df, dm;
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            df = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, WL - 1);
            dm = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, WL - 1);
            add_instr(op, df, dm, h);
        end
        run_trace("back_to_back");
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq_j();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
